// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues loads/stores on the data-memory bus,
// detects misalignment/bus faults/timeouts and registers the result for writeback.
package StaticPack;
  typedef enum logic [3:0] {
    NONE             = 4'd0,
    ILLEGAL_CODE     = 4'd2,
    LOAD_MIS_CODE    = 4'd4,
    LOAD_FAULT_CODE  = 4'd5,
    STORE_MIS_CODE   = 4'd6,
    STORE_FAULT_CODE = 4'd7
  } trapType_;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} writebackType_;
  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD} memorySize_;

  typedef struct packed {
    logic          valid;
    logic [31:0]   programCounter;
    logic [31:0]   programCounterPlus4;
    logic [31:0]   result;
    logic [31:0]   storeData;
    logic [4:0]    destinationRegister;
    writebackType_ writebackType;
    logic          memoryReadEnable;
    logic          memoryWriteEnable;
    memorySize_    memorySize;
    logic          memorySigned;
    trapType_      trapType;
    logic [11:0]   destinationCSR;
    logic [31:0]   oldCSRValue;
    logic [1:0]    CSROp;
    logic          CSRWriteIntent;
  } executeMemoryPayload_;

  typedef struct packed {
    logic          valid;
    logic [31:0]   programCounter;
    logic [31:0]   programCounterPlus4;
    logic [31:0]   result;
    logic [4:0]    destinationRegister;
    writebackType_ writebackType;
    trapType_      trapType;
    logic [31:0]   faultingAddress;
    logic [11:0]   destinationCSR;
    logic [31:0]   oldCSRValue;
    logic [1:0]    CSROp;
    logic          CSRWriteIntent;
  } memoryWritebackPayload_;

  typedef struct packed {
    logic stall;
    logic flush;
  } control;
endpackage

module memory_access import StaticPack::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  executeMemoryPayload_   executeMemoryPayload,
  input  control                 memoryWritebackControl,
  output memoryWritebackPayload_ memoryWritebackPayload,
  output logic                   memStall,
  output logic                   dmemReqValid,
  input  logic                   dmemReqReady,
  output logic                   dmemWrite,
  output logic [31:0]            dmemAddr,
  output logic [31:0]            dmemWriteData,
  output logic [3:0]             dmemByteEnable,
  input  logic                   dmemRspValid,
  input  logic [31:0]            dmemRspData,
  input  logic                   dmemRspError
);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  executeMemoryPayload_   p;
  memoryWritebackPayload_ wb_q, wb_d, wb_next;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        held_q, held_d, held_err_q, held_err_d, held_to_q, held_to_d;
  logic [31:0] held_data_q, held_data_d;

  logic        stall, flush, is_mem, misaligned, access, is_store, timeout_hit;
  logic [1:0]  off;
  logic        req, stall_o, got, got_err, got_to;
  logic [31:0] got_data, shifted, load_val;

  assign p           = executeMemoryPayload;
  assign stall       = memoryWritebackControl.stall;
  assign flush       = memoryWritebackControl.flush;
  assign off         = p.result[1:0];
  assign is_store    = p.memoryWriteEnable;
  assign is_mem      = p.valid && (p.trapType == NONE) && (p.memoryReadEnable || p.memoryWriteEnable);
  assign misaligned  = ((p.memorySize == MEM_HALF) && off[0]) ||
                       ((p.memorySize == MEM_WORD) && (off != 2'b00));
  assign access      = is_mem && !misaligned;
  // Fires in the WAIT cycle whose increment would reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) >= TIMEOUT_CYCLES);

  assign dmemAddr  = {p.result[31:2], 2'b00};
  assign dmemWrite = is_store;

  always_comb begin
    dmemByteEnable = 4'b1111;
    dmemWriteData  = '0;
    if (is_store) begin
      unique case (p.memorySize)
        MEM_BYTE: begin
          dmemByteEnable = 4'b0001 << off;
          dmemWriteData  = {4{p.storeData[7:0]}};
        end
        MEM_HALF: begin
          dmemByteEnable = 4'b0011 << off;
          dmemWriteData  = {2{p.storeData[15:0]}};
        end
        default: dmemWriteData = p.storeData;
      endcase
    end
  end

  // A response that lands while writeback is stalled is parked in held_*
  // so the instruction completes exactly once when the stall drops.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = 1'b0;
    held_d      = held_q;
    held_data_d = held_data_q;
    held_err_d  = held_err_q;
    held_to_d   = held_to_q;
    req         = 1'b0;
    stall_o     = 1'b0;
    got         = 1'b0;
    got_err     = 1'b0;
    got_to      = 1'b0;
    got_data    = held_data_q;
    unique case (state_q)
      IDLE: begin
        if (access && !flush && (!stall || pend_q)) begin
          req     = 1'b1;
          stall_o = 1'b1;
          if (dmemReqReady) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (held_q) begin
          got     = 1'b1;
          got_err = held_err_q;
          got_to  = held_to_q;
        end else if (dmemRspValid) begin
          got      = 1'b1;
          got_err  = dmemRspError;
          got_data = dmemRspData;
        end else if (timeout_hit) begin
          got     = 1'b1;
          got_err = 1'b1;
          got_to  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        stall_o = !got && !flush;
        if (flush) begin
          held_d  = 1'b0;
          cnt_d   = '0;
          state_d = (got && !got_to) ? IDLE : DRAIN;
        end else if (got && stall) begin
          held_d      = 1'b1;
          held_data_d = got_data;
          held_err_d  = got_err;
          held_to_d   = got_to;
        end else if (got) begin
          held_d  = 1'b0;
          cnt_d   = '0;
          state_d = got_to ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        stall_o = access && !flush;
        if (dmemRspValid || timeout_hit) state_d = IDLE;
        else                             cnt_d   = cnt_q + 32'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign memStall     = stall_o && !reset;
  assign dmemReqValid = req && !reset;

  always_comb begin
    shifted = got_data >> {off, 3'b000};
    unique case (p.memorySize)
      MEM_BYTE: load_val = {{24{p.memorySigned & shifted[7]}}, shifted[7:0]};
      MEM_HALF: load_val = {{16{p.memorySigned & shifted[15]}}, shifted[15:0]};
      default:  load_val = got_data;
    endcase
  end

  always_comb begin
    wb_next                     = '0;
    wb_next.valid               = p.valid;
    wb_next.programCounter      = p.programCounter;
    wb_next.programCounterPlus4 = p.programCounterPlus4;
    wb_next.result              = p.result;
    wb_next.destinationRegister = p.destinationRegister;
    wb_next.writebackType       = p.writebackType;
    wb_next.trapType            = p.trapType;
    wb_next.destinationCSR      = p.destinationCSR;
    wb_next.oldCSRValue         = p.oldCSRValue;
    wb_next.CSROp               = p.CSROp;
    wb_next.CSRWriteIntent      = p.CSRWriteIntent;
    if (is_mem && misaligned) begin
      wb_next.trapType        = is_store ? STORE_MIS_CODE : LOAD_MIS_CODE;
      wb_next.faultingAddress = p.result;
      wb_next.writebackType   = WB_NONE;
    end else if (got && got_err) begin
      wb_next.trapType        = is_store ? STORE_FAULT_CODE : LOAD_FAULT_CODE;
      wb_next.faultingAddress = p.result;
      wb_next.writebackType   = WB_NONE;
    end else if (got && !is_store) begin
      wb_next.result = load_val;
    end
  end

  always_comb begin
    wb_d = wb_q;
    if (flush) begin
      wb_d.valid = 1'b0;
    end else if (!stall) begin
      if (stall_o) wb_d.valid = 1'b0;
      else         wb_d       = wb_next;
    end
  end

  assign memoryWritebackPayload = wb_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      held_q      <= 1'b0;
      held_data_q <= '0;
      held_err_q  <= 1'b0;
      held_to_q   <= 1'b0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      held_q      <= held_d;
      held_data_q <= held_data_d;
      held_err_q  <= held_err_d;
      held_to_q   <= held_to_d;
      wb_q        <= wb_d;
    end
  end
endmodule
